// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PC sequencer.
//   state_t      - control FSM states (IDLE, RUN, HALT)
//   pc_op_t      - next-PC selection handed to pc_next_calc
//   LUT_W        - width of the branch-target LUT index
//   REL_ABS_BIT  - branch_sel bit choosing absolute (1) or relative (0) targets
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_REL  = 2'd2,
        OP_ABS  = 2'd3
    } pc_op_t;

    localparam int LUT_W       = 3;
    localparam int REL_ABS_BIT = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/fetch bundle between the core (master) and the
// PC sequencer (slave).
//   master drives: start, stall, halt, branch_en, branch_taken, branch_sel,
//                  lut_target (returned by the branch-target LUT)
//   slave drives:  lut_addr, pc, running, done, instr_count
//                  fault (only when PC_BOUNDS_CHECK_EN is defined)
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int D     = 12,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             halt;
    logic             branch_en;
    logic             branch_taken;
    logic [LUT_W-1:0] branch_sel;
    logic [LUT_W-1:0] lut_addr;
    logic [D-1:0]     lut_target;
    logic [D-1:0]     pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_count;
`ifdef PC_BOUNDS_CHECK_EN
    logic             fault;
`endif

    modport master (
        output start, stall, halt, branch_en, branch_taken, branch_sel, lut_target,
        input  lut_addr, pc, running, done, instr_count
`ifdef PC_BOUNDS_CHECK_EN
        , input fault
`endif
    );

    modport slave (
        input  start, stall, halt, branch_en, branch_taken, branch_sel, lut_target,
        output lut_addr, pc, running, done, instr_count
`ifdef PC_BOUNDS_CHECK_EN
        , output fault
`endif
    );

endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC mux/adder.
//   pc         - current program counter
//   lut_target - branch target from the LUT (offset for OP_REL, address for OP_ABS)
//   op         - hold / increment / relative / absolute
//   pc_next    - candidate next PC; additions wrap modulo 2^D by design
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [D-1:0] pc,
    input  logic [D-1:0] lut_target,
    input  pc_op_t        op,
    output logic [D-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        unique case (op)
            OP_INC:  pc_next = pc + D'(1);
            OP_REL:  pc_next = pc + lut_target;
            OP_ABS:  pc_next = lut_target;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and IDLE/RUN/HALT fetch sequencer.
//   Clk   - core clock, rising edge
//   Reset - asynchronous, active-high
//   bus   - pc_sequencer_if slave: start/stall/halt/branch controls in,
//           lut_addr out / lut_target in, pc, running, done, instr_count out
// Optional build macro PC_BOUNDS_CHECK_EN: adds PROG_LEN and bus.fault; any
// next PC at or beyond PROG_LEN halts with the PC parked on the faulting
// instruction.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter int           CNT_W      = 16
`ifdef PC_BOUNDS_CHECK_EN
    , parameter int         PROG_LEN   = 4096
`endif
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);

    state_t           state, state_next;
    pc_op_t           op;
    logic [D-1:0]     pc_q, pc_d, pc_cand;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             taken;
`ifdef PC_BOUNDS_CHECK_EN
    logic             fault_q, fault_d;
`endif

    assign bus.lut_addr = bus.branch_sel;
    assign taken   = bus.branch_en & bus.branch_taken & ~bus.stall & ~bus.halt;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Op selection depends only on state and inputs, so the bounds check
    // below can look at the candidate without forming a combinational loop.
    always_comb begin
        op = OP_HOLD;
        if (state == RUN && !bus.halt && !bus.stall) begin
            if (taken)
                op = bus.branch_sel[REL_ABS_BIT] ? OP_ABS : OP_REL;
            else
                op = OP_INC;
        end
    end

    pc_next_calc #(.D(D)) u_next (
        .pc         (pc_q),
        .lut_target (bus.lut_target),
        .op         (op),
        .pc_next    (pc_cand)
    );

    always_comb begin
        state_next = state;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
`ifdef PC_BOUNDS_CHECK_EN
        fault_d    = fault_q;
`endif
        unique case (state)
            IDLE: begin
                pc_d = START_ADDR;
                if (bus.start) begin
                    state_next = RUN;
                    cnt_d      = '0;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    state_next = HALT;
                    cnt_d      = cnt_inc;
                end else if (!bus.stall) begin
                    cnt_d = cnt_inc;
                    pc_d  = pc_cand;
`ifdef PC_BOUNDS_CHECK_EN
                    if (32'(pc_cand) >= 32'(PROG_LEN)) begin
                        state_next = HALT;
                        pc_d       = pc_q;
                        fault_d    = 1'b1;
                    end
`endif
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_next = RUN;
                    pc_d       = START_ADDR;
                    cnt_d      = '0;
`ifdef PC_BOUNDS_CHECK_EN
                    fault_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                pc_d       = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
`ifdef PC_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PC_BOUNDS_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.pc          = pc_q;
    assign bus.running     = (state == RUN);
    assign bus.done        = (state == HALT);
    assign bus.instr_count = cnt_q;
`ifdef PC_BOUNDS_CHECK_EN
    assign bus.fault       = fault_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register and sequences instruction fetch for the single-cycle core. Each cycle it chooses the next PC: increment, hold (stall), relative branch, or absolute jump. Branch targets come from the external branch-target LUT; this block drives the LUT index and consumes the returned target. It also runs the IDLE/RUN/HALT control FSM and produces the done flag used by the testbench.

Parameters:
D, 12, PC / instruction-address width in bits
START_ADDR, 0, PC value loaded on reset, on start from IDLE, and on restart from HALT
CNT_W, 16, width of the retired-instruction counter
PROG_LEN, 4096, number of valid instruction addresses (used only with the optional feature)

Ports:
Clk  input  1  core clock, rising-edge
Reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins execution from IDLE or restarts from HALT
stall  input  1  hold PC this cycle (e.g. multi-cycle datapath op)
halt  input  1  decoded halt instruction at current PC
branch_en  input  1  current instruction is a branch/jump
branch_taken  input  1  branch condition true (ignored unless branch_en)
branch_sel  input  3  LUT index from instruction field
lut_addr  output  3  index to branch-target LUT (combinational = branch_sel)
lut_target  input  D  target returned by LUT, same cycle
pc  output  D  current program counter
running  output  1  1 while FSM in RUN
done  output  1  1 while FSM in HALT
instr_count  output  CNT_W  instructions retired since last start (saturating)

Behaviour:
- Reset (async, active-high): state=IDLE, pc=START_ADDR, instr_count=0, running=0, done=0. Reset mid-RUN aborts immediately; no partial update survives.
- FSM states: IDLE, RUN, HALT.
  - IDLE: pc held at START_ADDR; start -> RUN, pc stays START_ADDR, instr_count<=0.
  - RUN: one instruction per unstalled cycle. Next-state/PC priority, highest first: halt (-> HALT, pc held, instr_count+1) > stall (pc held, no count) > taken branch > increment.
  - HALT: pc frozen; done=1; start -> RUN with pc<=START_ADDR, instr_count<=0. All other inputs ignored.
- start while in RUN is ignored.
- Taken branch = branch_en & branch_taken & !stall & !halt.
  - branch_sel[2]=0: relative, pc_next = (pc + lut_target) mod 2^D; negative targets are D-bit two's complement, wrap is intentional (pc=3, target=-5 -> 4094 for D=12).
  - branch_sel[2]=1: absolute, pc_next = lut_target.
- Not-taken or non-branch: pc_next = (pc + 1) mod 2^D; pc=2^D-1 wraps to 0.
- instr_count increments on each unstalled RUN cycle (including the halting one); saturates at 2^CNT_W-1.
- Latency: pc updates on the rising edge after the decision; lut_addr -> lut_target path is combinational within the cycle.
- halt and branch together: halt wins, branch discarded. stall and halt together: halt wins (halt is not stallable).
- running/done are registered, decoded from state.

Optional Feature:
Macro PC_BOUNDS_CHECK_EN. With it: adds output fault (1 bit, reset 0); in RUN, if pc_next >= PROG_LEN on an unstalled cycle, FSM goes to HALT, pc held at the faulting instruction, fault=1, done=1; fault clears on start or Reset. Without it: no fault port, PROG_LEN unused, wrap-around as above.

Decomposition:
- Shared package pc_pkg: state enum {IDLE, RUN, HALT}, LUT_W=3, REL_ABS_BIT=2 constant for branch_sel.
- One natural sub-module: pc_next_calc (combinational next-PC mux/adder: inc, rel, abs, hold). FSM and counters remain in pc_sequencer.

Test Plan:
- Reset, start, 10 unstalled cycles without branches -> pc=10, instr_count=10, running=1.
- pc=4, branch_sel=3'b011, lut_target=-1, taken -> pc=3 next cycle; branch_taken=0 instead -> pc=5.
- pc=3, branch_sel=3'b001, lut_target=-5 -> pc=4094 (wrap); pc=4095, no branch -> pc=0.
- pc=7, branch_sel=3'b101, lut_target=200, taken, with stall=1 -> pc stays 7, count unchanged; stall=0 -> pc=200.
- halt with simultaneous taken branch at pc=20 -> state HALT, pc=20, done=1; start -> pc=0, instr_count=0, RUN.
- Reset asserted mid-cycle during RUN at pc=50 -> pc=0 and IDLE asynchronously; start in RUN ignored. With PC_BOUNDS_CHECK_EN, PROG_LEN=64, absolute jump to 100 -> HALT, fault=1, pc unchanged.
